s713_stim_misr: RTL and testbench

S713_STIM_MISR -- requirements
Module: s713_stim_misr

---
 rtl/s713_stim_misr_pkg.sv | 23 ++
 rtl/lfsr_shift.sv | 44 ++++
 rtl/s713_stim_misr.sv | 199 +++++++++++++++++++
 tb/tb_s713_stim_misr.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s713_stim_misr_pkg.sv
// Shared definitions for the s713_stim_misr pattern generator / signature
// compactor: FSM state encoding, default widths, seed and feedback masks.
package s713_stim_misr_pkg;

  // Default DUT interface widths.
  localparam int PI_W_DEF = 35;
  localparam int PO_W_DEF = 23;

  // Default LFSR seed and feedback masks (taps 35/33 and 23/18).
  localparam logic [34:0] SEED_DEF      = 35'h1;
  localparam logic [34:0] LFSR_TAPS_DEF = 35'h5_0000_0000;
  localparam logic [22:0] MISR_TAPS_DEF = 23'h42_0000;

  // Run-control FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/lfsr_shift.sv
// Generic shift register with XOR feedback. With mode=0 it free-runs as an
// LFSR; with mode=1 the din vector is XORed in each step (MISR behaviour).
// A synchronous load has priority over the shift enable.
module lfsr_shift #(
  parameter int           W       = 8,
  parameter logic [W-1:0] TAPS    = '0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         mode,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_next;

  // Next-value computation: shift left, feedback into bit 0, optional XOR-in.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    q_next = {q[W-2:0], ^(q & TAPS)};
    if (mode) begin
      q_next = q_next ^ din;
    end
  end

  // State register: load wins over shift, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/s713_stim_misr.sv
// Pseudo-random stimulus generator and MISR signature compactor for a DUT.
// A run resets the DUT (LOAD), applies n_pat LFSR patterns (RUN), flushes
// the DUT pipeline for DRAIN_CYC cycles while compacting, then pulses done.
// Optional feature macro: GOLDEN_CMP_EN adds a golden signature input and a
// registered pass flag.
module s713_stim_misr
  import s713_stim_misr_pkg::*;
#(
  parameter int              PI_W      = PI_W_DEF,
  parameter int              PO_W      = PO_W_DEF,
  parameter int              CNT_W     = 16,
  parameter int              DRAIN_CYC = 4,
  parameter logic [PI_W-1:0] SEED      = PI_W'(SEED_DEF),
  parameter logic [PI_W-1:0] LFSR_TAPS = PI_W'(LFSR_TAPS_DEF),
  parameter logic [PO_W-1:0] MISR_TAPS = PO_W'(MISR_TAPS_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_pat,
  output logic             busy,
  output logic             done,
  output logic             dut_rst_n,
  output logic [PI_W-1:0]  dut_pi,
  input  logic [PO_W-1:0]  dut_po,
  output logic [PO_W-1:0]  signature
`ifdef GOLDEN_CMP_EN
  ,
  input  logic [PO_W-1:0]  golden,
  output logic             pass
`endif
);

  // Drain counter only needs to hold DRAIN_CYC down to 1.
  localparam int DRN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DRN_W-1:0]  drn_cnt;
  logic [PI_W-1:0]   lfsr;
  logic [PI_W-1:0]   pi_last;
  logic              load_cyc;
  logic              lfsr_en;
  logic              misr_en;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort beats start in IDLE and cancels any active run.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start && !abort) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort)                state_next = ST_IDLE;
        else if (n_pat != '0)     state_next = ST_RUN;
        else                      state_next = ST_DRAIN;
      end
      ST_RUN: begin
        if (abort)                       state_next = ST_IDLE;
        else if (cnt == CNT_W'(1))       state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)                       state_next = ST_IDLE;
        else if (drn_cnt == DRN_W'(1))   state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode: status flags, DUT reset/stimulus and datapath enables.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    dut_rst_n = rst_n;
    dut_pi    = pi_last;
    load_cyc  = 1'b0;
    lfsr_en   = 1'b0;
    misr_en   = 1'b0;
    case (state)
      ST_LOAD: begin
        busy      = 1'b1;
        load_cyc  = 1'b1;
        dut_rst_n = 1'b0;
        dut_pi    = SEED;
      end
      ST_RUN: begin
        busy    = 1'b1;
        lfsr_en = 1'b1;
        misr_en = 1'b1;
        dut_pi  = lfsr;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        misr_en = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Pattern/drain counters and the held stimulus shown outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      drn_cnt <= '0;
      pi_last <= SEED;
    end else begin
      case (state)
        ST_LOAD: begin
          cnt     <= n_pat;
          drn_cnt <= DRN_W'(DRAIN_CYC);
          pi_last <= SEED;
        end
        ST_RUN: begin
          cnt     <= cnt - CNT_W'(1);
          pi_last <= lfsr;
        end
        ST_DRAIN: begin
          drn_cnt <= drn_cnt - DRN_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Free-running pattern LFSR, reseeded in LOAD.
  lfsr_shift #(
    .W       (PI_W),
    .TAPS    (LFSR_TAPS),
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_cyc),
    .load_val (SEED),
    .en       (lfsr_en),
    .mode     (1'b0),
    .din      ({PI_W{1'b0}}),
    .q        (lfsr)
  );

  // Response compactor, cleared in LOAD; its contents are the signature and
  // persist until the next LOAD (an abort leaves the partial value visible).
  lfsr_shift #(
    .W       (PO_W),
    .TAPS    (MISR_TAPS),
    .RST_VAL ({PO_W{1'b0}})
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_cyc),
    .load_val ({PO_W{1'b0}}),
    .en       (misr_en),
    .mode     (1'b1),
    .din      (dut_po),
    .q        (signature)
  );

`ifdef GOLDEN_CMP_EN
  logic [PO_W-1:0] misr_next;

  // Value the MISR takes on the edge into DONE, i.e. the final signature.
  always_comb begin
    misr_next = {signature[PO_W-2:0], ^(signature & MISR_TAPS)} ^ dut_po;
  end

  // Pass flag: cleared at LOAD, set from the final compaction on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if (state == ST_LOAD) begin
      pass <= 1'b0;
    end else if (state == ST_DRAIN && state_next == ST_DONE) begin
      pass <= (misr_next == golden);
    end
  end
`endif

endmodule

// File: tb/tb_s713_stim_misr.sv
// Self-checking bench for s713_stim_misr. A stand-in DUT derives dut_po from
// dut_pi (or drives a constant); expected signatures are pushed to a queue
// when a run starts and popped when done is seen.
module tb_s713_stim_misr;

  localparam int              PI_W     = 35;
  localparam int              PO_W     = 23;
  localparam int              CNT_W    = 16;
  localparam int              TB_DRAIN = 1;
  localparam logic [PI_W-1:0] SEED_TB  = 35'h1;
  localparam logic [PI_W-1:0] LFSR_T   = 35'h5_0000_0000;
  localparam logic [PO_W-1:0] MISR_T   = 23'h42_0000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_pat;
  logic             busy;
  logic             done;
  logic             dut_rst_n;
  logic [PI_W-1:0]  dut_pi;
  logic [PO_W-1:0]  dut_po;
  logic [PO_W-1:0]  signature;
`ifdef GOLDEN_CMP_EN
  logic [PO_W-1:0]  golden;
  logic             pass;
`endif

  logic             po_const_mode;
  logic [PO_W-1:0]  po_const;
  logic [PO_W-1:0]  exp_q[$];
  int               checks;
  int               errors;

  s713_stim_misr #(
    .PI_W      (PI_W),
    .PO_W      (PO_W),
    .CNT_W     (CNT_W),
    .DRAIN_CYC (TB_DRAIN),
    .SEED      (SEED_TB),
    .LFSR_TAPS (LFSR_T),
    .MISR_TAPS (MISR_T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .n_pat     (n_pat),
    .busy      (busy),
    .done      (done),
    .dut_rst_n (dut_rst_n),
    .dut_pi    (dut_pi),
    .dut_po    (dut_po),
    .signature (signature)
`ifdef GOLDEN_CMP_EN
    ,
    .golden    (golden),
    .pass      (pass)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PO_W-1:0] fake_po(input logic [PI_W-1:0] p);
    return p[PO_W-1:0] ^ p[PI_W-1:PI_W-PO_W];
  endfunction

  function automatic logic [PO_W-1:0] po_of(input logic [PI_W-1:0] p);
    return po_const_mode ? po_const : fake_po(p);
  endfunction

  assign dut_po = po_of(dut_pi);

  // Reference: n_run RUN compactions followed by n_drain DRAIN compactions.
  function automatic logic [PO_W-1:0] model_sig(input int n_run, input int n_drain);
    logic [PI_W-1:0] l;
    logic [PI_W-1:0] p;
    logic [PO_W-1:0] m;
    l = SEED_TB;
    p = SEED_TB;
    m = '0;
    for (int k = 0; k < n_run; k++) begin
      p = l;
      m = {m[PO_W-2:0], ^(m & MISR_T)} ^ po_of(p);
      l = {l[PI_W-2:0], ^(l & LFSR_T)};
    end
    for (int d = 0; d < n_drain; d++) begin
      m = {m[PO_W-2:0], ^(m & MISR_T)} ^ po_of(p);
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 of cycle cyc0; waits for done, checks latency and
  // signature against the scoreboard, then the single-cycle done pulse.
  task automatic finish_run(input int cyc0, input int n, input string name);
    int              cyc;
    bit              seen;
    logic [PO_W-1:0] exp;
    cyc  = cyc0;
    seen = 1'b0;
    while (!seen && cyc < cyc0 + 300) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout done not seen by cycle %0d", name, cyc);
    end else if (cyc != n + TB_DRAIN + 2) begin
      errors++;
      $display("FAIL %s_latency got cycle %0d want %0d", name, cyc, n + TB_DRAIN + 2);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty no expected signature queued", name);
    end else begin
      exp = exp_q.pop_front();
      if (!seen || signature !== exp) begin
        errors++;
        $display("FAIL %s_sig got %h want %h", name, signature, exp);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_in_done got %b want 0", name, busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse got %b want 0", name, done);
    end
    step();
  endtask

  task automatic do_run(input logic [CNT_W-1:0] n, input logic [PO_W-1:0] exp,
                        input string name);
    exp_q.push_back(exp);
    n_pat = n;
    start = 1'b1;
    step();
    start = 1'b0;
    finish_run(1, int'(n), name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (dut_rst_n !== 1'b0) begin errors++; $display("FAIL rst_dut_rst_n got %b want 0", dut_rst_n); end
    if (signature !== '0)   begin errors++; $display("FAIL rst_sig got %h want 0", signature); end
    if (dut_pi !== SEED_TB) begin errors++; $display("FAIL rst_pi got %h want %h", dut_pi, SEED_TB); end
`ifdef GOLDEN_CMP_EN
    checks++;
    if (pass !== 1'b0)      begin errors++; $display("FAIL rst_pass got %b want 0", pass); end
`endif
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sequence();
    logic [PI_W-1:0] exp_pi;
    po_const_mode = 1'b0;
    exp_q.push_back(model_sig(3, TB_DRAIN));
    n_pat = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    checks += 2;
    if (dut_rst_n !== 1'b0) begin errors++; $display("FAIL seq_load_dut_rst got %b want 0", dut_rst_n); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL seq_load_busy got %b want 1", busy); end
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      exp_pi = PI_W'(1) << k;
      checks += 2;
      if (dut_pi !== exp_pi) begin
        errors++;
        $display("FAIL seq_pi%0d got %h want %h", k, dut_pi, exp_pi);
      end
      if (dut_rst_n !== 1'b1) begin
        errors++;
        $display("FAIL seq_run_dut_rst%0d got %b want 1", k, dut_rst_n);
      end
    end
    step();
    finish_run(5, 3, "seq");
  endtask

  task automatic test_misr();
    po_const_mode = 1'b1;
    po_const      = 23'h1;
    do_run(16'd1, 23'h3, "misr");
  endtask

  task automatic test_zero();
    po_const_mode = 1'b1;
    po_const      = '0;
    exp_q.push_back('0);
    n_pat = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= TB_DRAIN + 1; c++) begin
      @(negedge clk);
      checks++;
      if (dut_pi !== SEED_TB) begin
        errors++;
        $display("FAIL zero_pi_c%0d got %h want %h", c, dut_pi, SEED_TB);
      end
      step();
    end
    finish_run(TB_DRAIN + 2, 0, "zero");
  endtask

  task automatic test_abort();
    bit              stray;
    logic [PO_W-1:0] partial;
    po_const_mode = 1'b0;
    partial       = model_sig(2, 0);
    n_pat = 16'd5;
    start = 1'b1;
    step();                       // cycle 1: LOAD
    start = 1'b0;
    step();                       // cycle 2: RUN, start again while busy
    start = 1'b1;
    step();                       // cycle 3: RUN
    start = 1'b0;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b1)      begin errors++; $display("FAIL abort_busy_run got %b want 1", busy); end
    if (dut_rst_n !== 1'b1) begin errors++; $display("FAIL abort_start_ignored dut_rst_n got %b want 1", dut_rst_n); end
    abort = 1'b1;
    step();                       // cycle 4: back in IDLE
    abort = 1'b0;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL abort_done got %b want 0", done); end
    if (signature !== partial) begin errors++; $display("FAIL abort_sig_kept got %h want %h", signature, partial); end
    stray = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL abort_idle_quiet got activity want none"); end
    step();
    do_run(16'd5, model_sig(5, TB_DRAIN), "abort_rerun");
  endtask

  task automatic test_back_to_back();
    int ns[3] = '{2, 7, 16};
    po_const_mode = 1'b0;
    foreach (ns[i]) begin
      do_run(CNT_W'(ns[i]), model_sig(ns[i], TB_DRAIN), $sformatf("b2b_n%0d", ns[i]));
    end
    po_const_mode = 1'b1;
    po_const      = 23'h5A5A5;
    do_run(16'd4, model_sig(4, TB_DRAIN), "b2b_const");
  endtask

  task automatic test_reset_midrun();
    po_const_mode = 1'b0;
    n_pat = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();                       // cycle 3: RUN
    rst_n = 1'b0;
    @(negedge clk);
    checks += 5;
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL mid_rst_done got %b want 0", done); end
    if (dut_rst_n !== 1'b0) begin errors++; $display("FAIL mid_rst_dut_rst_n got %b want 0", dut_rst_n); end
    if (signature !== '0)   begin errors++; $display("FAIL mid_rst_sig got %h want 0", signature); end
    if (dut_pi !== SEED_TB) begin errors++; $display("FAIL mid_rst_pi got %h want %h", dut_pi, SEED_TB); end
    step();
    rst_n = 1'b1;
    step();
    do_run(16'd3, model_sig(3, TB_DRAIN), "post_reset");
  endtask

`ifdef GOLDEN_CMP_EN
  task automatic test_golden();
    po_const_mode = 1'b1;
    po_const      = 23'h1;
    golden        = 23'h3;
    do_run(16'd1, 23'h3, "gold_hit");
    checks++;
    if (pass !== 1'b1) begin errors++; $display("FAIL gold_hit_pass got %b want 1", pass); end
    golden = 23'h2;
    do_run(16'd1, 23'h3, "gold_miss");
    checks++;
    if (pass !== 1'b0) begin errors++; $display("FAIL gold_miss_pass got %b want 0", pass); end
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    n_pat         = '0;
    po_const_mode = 1'b1;
    po_const      = '0;
`ifdef GOLDEN_CMP_EN
    golden        = '0;
`endif
    test_reset();
    test_sequence();
    test_misr();
    test_zero();
    test_abort();
    test_back_to_back();
    test_reset_midrun();
`ifdef GOLDEN_CMP_EN
    test_golden();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
